// File: rtl/draw_layers_if.sv
// draw_layers_if: bundles the position/colour configuration, the pixel
// stream, and the composited outputs of the layer compositor.
//   master : game logic / video timing side (drives config + pixel coords)
//   slave  : draw_layers (drives colour, pix_valid and collision report)
interface draw_layers_if #(
  parameter int NUM_OBJ = 4,
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int SW      = 8,
  parameter int CW      = 4
);
  logic                    frame_start;
  logic [NUM_OBJ*XW-1:0]   obj_x;
  logic [NUM_OBJ*YW-1:0]   obj_y;
  logic [NUM_OBJ*SW-1:0]   obj_half;
  logic [NUM_OBJ-1:0]      obj_en;
  logic [NUM_OBJ*3*CW-1:0] obj_rgb;
  logic [3*CW-1:0]         bg_rgb;
  logic [3*CW-1:0]         border_rgb;
  logic [XW-1:0]           draw_x;
  logic [YW-1:0]           draw_y;
  logic                    draw_valid;
  logic [CW-1:0]           r;
  logic [CW-1:0]           g;
  logic [CW-1:0]           b;
  logic                    pix_valid;
  logic [NUM_OBJ-1:0]      collide_mask;
  logic                    collide_pulse;

  modport master (
    output frame_start, obj_x, obj_y, obj_half, obj_en, obj_rgb,
           bg_rgb, border_rgb, draw_x, draw_y, draw_valid,
    input  r, g, b, pix_valid, collide_mask, collide_pulse
  );

  modport slave (
    input  frame_start, obj_x, obj_y, obj_half, obj_en, obj_rgb,
           bg_rgb, border_rgb, draw_x, draw_y, draw_valid,
    output r, g, b, pix_valid, collide_mask, collide_pulse
  );
endinterface

// File: rtl/draw_layers.sv
// draw_layers: two-stage pipelined pixel compositor.
// Draws a bordered playfield with NUM_OBJ square objects (index 0 has the
// highest priority) and reports, once per frame, which objects overlapped
// object 0 during the previous frame.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous reset, active high
//   bus  - draw_layers_if.slave: per-frame object config (sampled into
//          shadow registers on frame_start), pixel coordinates in,
//          r/g/b/pix_valid out (2 clk latency), collide_mask/collide_pulse.
module draw_layers #(
  parameter int NUM_OBJ = 4,
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int SW      = 8,
  parameter int CW      = 4,
  parameter int X_MIN   = 11,
  parameter int X_MAX   = 1428,
  parameter int Y_MIN   = 11,
  parameter int Y_MAX   = 888
) (
  input logic         clk,
  input logic         rst,
  draw_layers_if.slave bus
);
  localparam int RGBW = 3 * CW;

  localparam logic [XW-1:0] X_MIN_V = X_MIN[XW-1:0];
  localparam logic [XW-1:0] X_MAX_V = X_MAX[XW-1:0];
  localparam logic [YW-1:0] Y_MIN_V = Y_MIN[YW-1:0];
  localparam logic [YW-1:0] Y_MAX_V = Y_MAX[YW-1:0];

  // shadow (per-frame) copies of the object configuration
  logic [NUM_OBJ*XW-1:0]   sh_x_q,   sh_x_d;
  logic [NUM_OBJ*YW-1:0]   sh_y_q,   sh_y_d;
  logic [NUM_OBJ*SW-1:0]   sh_h_q,   sh_h_d;
  logic [NUM_OBJ-1:0]      sh_en_q,  sh_en_d;
  logic [NUM_OBJ*RGBW-1:0] sh_rgb_q, sh_rgb_d;

  // stage 1
  logic [NUM_OBJ-1:0] hit_q, hit_d;
  logic               border_q, border_d;
  logic               valid1_q, valid1_d;

  // stage 2 / collision bookkeeping
  logic [RGBW-1:0]    rgb_q, rgb_d;
  logic               pix_valid_q, pix_valid_d;
  logic [NUM_OBJ-1:0] acc_q, acc_d;
  logic [NUM_OBJ-1:0] mask_q, mask_d;
  logic               pulse_q, pulse_d;

  // compare temporaries
  logic [XW:0] ox_w, ohx_w, dx_w;
  logic [YW:0] oy_w, ohy_w, dy_w;
  logic        x_ok, y_ok;
  logic [RGBW-1:0]    col;
  logic [NUM_OBJ-1:0] contrib;
  logic [NUM_OBJ-1:0] publish;

  // Shadow load; the _d values double as the bypass so a pixel presented in
  // the frame_start cycle is compared against the freshly loaded geometry.
  always_comb begin
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_h_d   = sh_h_q;
    sh_en_d  = sh_en_q;
    sh_rgb_d = sh_rgb_q;
    if (bus.frame_start) begin
      sh_x_d   = bus.obj_x;
      sh_y_d   = bus.obj_y;
      sh_h_d   = bus.obj_half;
      sh_en_d  = bus.obj_en;
      sh_rgb_d = bus.obj_rgb;
    end
  end

  // Stage 1: per-object strict-inequality box test at width+1 bits.
  always_comb begin
    hit_d = '0;
    ox_w  = '0;
    ohx_w = '0;
    oy_w  = '0;
    ohy_w = '0;
    x_ok  = 1'b0;
    y_ok  = 1'b0;
    dx_w  = {1'b0, bus.draw_x};
    dy_w  = {1'b0, bus.draw_y};
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox_w  = {1'b0, sh_x_d[i*XW +: XW]};
      oy_w  = {1'b0, sh_y_d[i*YW +: YW]};
      ohx_w = {{(XW+1-SW){1'b0}}, sh_h_d[i*SW +: SW]};
      ohy_w = {{(YW+1-SW){1'b0}}, sh_h_d[i*SW +: SW]};
      // lower bound clamps below 0: any coordinate satisfies it when h > centre
      x_ok = ((ohx_w > ox_w) || ((ox_w - ohx_w) < dx_w)) && ((ox_w + ohx_w) > dx_w);
      y_ok = ((ohy_w > oy_w) || ((oy_w - ohy_w) < dy_w)) && ((oy_w + ohy_w) > dy_w);
      hit_d[i] = sh_en_d[i] && x_ok && y_ok;
    end
    border_d = (bus.draw_x < X_MIN_V) || (bus.draw_x > X_MAX_V) ||
               (bus.draw_y < Y_MIN_V) || (bus.draw_y > Y_MAX_V);
    valid1_d = bus.draw_valid;
  end

  // Stage 2: priority mux and overlap accumulation. Colours come from the
  // registered shadow so a pixel still in flight at frame_start keeps the
  // colour of the frame it was computed in.
  always_comb begin
    col = border_q ? bus.border_rgb : bus.bg_rgb;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_q[i]) col = sh_rgb_q[i*RGBW +: RGBW];
    end
    rgb_d       = valid1_q ? col : '0;
    pix_valid_d = valid1_q;

    contrib = '0;
    for (int i = 1; i < NUM_OBJ; i++) begin
      contrib[i] = valid1_q && hit_q[0] && hit_q[i];
    end
    publish = acc_q | contrib;

    acc_d   = publish;
    mask_d  = mask_q;
    pulse_d = 1'b0;
    if (bus.frame_start) begin
      acc_d   = '0;
      mask_d  = publish;
      pulse_d = |publish;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_h_q      <= '0;
      sh_en_q     <= '0;
      sh_rgb_q    <= '0;
      hit_q       <= '0;
      border_q    <= 1'b0;
      valid1_q    <= 1'b0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      acc_q       <= '0;
      mask_q      <= '0;
      pulse_q     <= 1'b0;
    end else begin
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_h_q      <= sh_h_d;
      sh_en_q     <= sh_en_d;
      sh_rgb_q    <= sh_rgb_d;
      hit_q       <= hit_d;
      border_q    <= border_d;
      valid1_q    <= valid1_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      pulse_q     <= pulse_d;
    end
  end

  assign bus.r             = rgb_q[2*CW +: CW];
  assign bus.g             = rgb_q[CW +: CW];
  assign bus.b             = rgb_q[0 +: CW];
  assign bus.pix_valid     = pix_valid_q;
  assign bus.collide_mask  = mask_q;
  assign bus.collide_pulse = pulse_q;
endmodule

// File: doc/draw_layers.md
Name: draw_layers

Overview:
- Parametrised, pipelined pixel compositor that replaces the fixed two-object combinational drawer.
- Draws a bordered playfield plus NUM_OBJ square objects with fixed priority.
- Positions and sizes are double-buffered per frame, and overlaps with object 0 (the character) are reported once per frame.
- Sits between the game-logic position registers and the VGA timing/output stage.

Parameters:
- NUM_OBJ, 4, number of square objects; index 0 = character, highest priority.
- XW, 11, width of x coordinates.
- YW, 10, width of y coordinates.
- SW, 8, width of the object half-size field.
- CW, 4, bits per colour channel.
- X_MIN, 11, first interior column; border is x < X_MIN.
- X_MAX, 1428, last interior column; border is x > X_MAX.
- Y_MIN, 11, first interior row; border is y < Y_MIN.
- Y_MAX, 888, last interior row; border is y > Y_MAX.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at the start of each frame (first visible pixel).
- obj_x  in  NUM_OBJ*XW  object centre x; object i occupies bits [i*XW +: XW].
- obj_y  in  NUM_OBJ*YW  object centre y; same packing.
- obj_half  in  NUM_OBJ*SW  object half-size.
- obj_en  in  NUM_OBJ  object enable.
- obj_rgb  in  NUM_OBJ*3*CW  object colour, packed {r,g,b}.
- bg_rgb  in  3*CW  interior background colour.
- border_rgb  in  3*CW  border colour.
- draw_x  in  XW  current pixel x.
- draw_y  in  YW  current pixel y.
- draw_valid  in  1  current pixel is in the visible area.
- r  out  CW  red.
- g  out  CW  green.
- b  out  CW  blue.
- pix_valid  out  1  draw_valid delayed to align with r/g/b.
- collide_mask  out  NUM_OBJ  bit i set = object i overlapped object 0 during the previous frame; bit 0 always 0.
- collide_pulse  out  1  one-cycle strobe when collide_mask is updated with a nonzero value.

Behaviour:
- Reset: r, g, b, pix_valid, collide_mask, collide_pulse = 0. All shadow registers = 0, so all objects are disabled. Overlap accumulator = 0.
- Shadow load: on a clk edge with frame_start=1, shadow copies of obj_x, obj_y, obj_half, obj_en and obj_rgb are loaded from the inputs. Live inputs may change at any time; only shadow values are used for drawing.
- Pipeline stage 1, registered:
  - For each i: hit[i] = shadow_en[i] AND (x-h < draw_x < x+h) AND (y-h < draw_y < y+h). Both inequalities are strict.
  - Compare arithmetic is done at width+1 bits, unsigned. The lower bound is clamped at 0 when h > x, so there is no wrap-around. The upper bound does not wrap at maximum width.
  - h = 0 gives an empty object.
  - The border flag and draw_valid are registered alongside hit[i].
  - frame_start and the pixel in the same cycle: stage 1 uses the newly loaded shadow values (the load is bypassed into the compare).
- Pipeline stage 2, registered outputs:
  - Colour = obj_rgb of the lowest-index set hit[i], else border_rgb if the border flag is set, else bg_rgb.
  - If the stage-1 draw_valid was 0, r/g/b = 0.
  - Latency is exactly 2 clk from draw_x/draw_y/draw_valid to r/g/b/pix_valid. Throughput is 1 pixel/clk with no stalls.
- Overlap accumulator:
  - In stage 2, when valid AND hit[0] AND hit[i] for i>0, acc[i] is set.
  - On frame_start: collide_mask <= acc | (this cycle's contribution); acc <= 0. collide_pulse = 1 for that one cycle iff the new mask is nonzero.
  - A stage-2 hit in the frame_start cycle belongs to the ending frame, because the pipeline holds old-frame pixels.
  - collide_mask holds its value until the next frame_start.
- Disabled objects never hit, never draw and never collide.
- frame_start repeated on back-to-back cycles: each one reloads the shadows and publishes the mask (the second publish is normally 0, so no pulse).
- rst asserted mid-frame: all state clears immediately. Frames restart from the next frame_start.

Test Plan:
- Reset, then frame_start with obj 0 at (100,100), h=8, red, enabled. Sweep draw_x 90..110 at y=100 -> output red for x=93..107, bg_rgb elsewhere, each result exactly 2 clk after its input.
- Objects 0 and 1 both at (200,200), h=8, obj1 yellow. Pixel (200,200) -> red (priority). Next frame_start -> collide_mask=0b0010, collide_pulse high for 1 cycle.
- Obj 2 at x=3, h=8, pixel x=0,y=obj_y -> obj2 colour (clamped lower bound, no wrap). Pixel (5,500) with no objects -> border_rgb. Pixel (1429,500) -> border_rgb. Pixel (1428,500) -> bg_rgb.
- Change obj_x mid-frame without frame_start -> drawn position unchanged until the next frame_start, then at the new position.
- obj_en[1]=0 while overlapping obj 0 -> obj1 never drawn, collide_mask bit 1 = 0, no pulse.
- Assert rst mid-frame after an overlap -> outputs, collide_mask and acc = 0. Next frame_start -> collide_mask stays 0.
